// File: rtl/bfp_normalization.sv
// Float32 stream to block-floating-point: buffers block_size words, finds the shared exponent, right-aligns each mantissa.
// Optional BFP_ROUND_EN macro selects round-half-up alignment instead of truncation.
module bfp_normalization #(
    parameter int output_sign_fraction_size = 24,
    parameter int output_exponent_size      = 8,
    parameter int block_size                = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [31:0]                          in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [output_sign_fraction_size-1:0] out_sign_frac,
    output logic [output_exponent_size-1:0]      out_exp,
    output logic                                 out_last,
    output logic                                 exp_overflow
);

    localparam int            CW      = $clog2(block_size);
    localparam logic [CW-1:0] LAST    = CW'(block_size - 1);
    localparam logic [8:0]    EXP_MAX = 9'((1 << output_exponent_size) - 1);

    typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

    state_t        state_r, next_state_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_inc_s;
    logic [7:0]    max_e_r;
    logic [7:0]    max_next_s;
    logic [7:0]    e_in_s;
    logic          accept_s;
    logic          emit_hs_s;
    logic [31:0]   buffer_r [block_size];

    // Align one buffered float to the shared exponent; sign is kept even when the magnitude flushes.
    function automatic logic [23:0] align(input logic [31:0] w, input logic [7:0] me);
        logic [7:0]  e;
        logic [23:0] m24;
        logic [8:0]  sh;
        logic [22:0] mag;
`ifdef BFP_ROUND_EN
        logic [4:0]  idx;
        logic [23:0] sum;
`endif
        e   = w[30:23];
        m24 = (e == 8'd0) ? 24'd0 : {1'b1, w[22:0]};
        sh  = 9'd1 + {1'b0, me - e};
`ifdef BFP_ROUND_EN
        if (sh > 9'd24) begin
            mag = 23'd0;
        end else begin
            idx = sh[4:0] - 5'd1;
            sum = 24'(m24 >> sh) + {23'd0, m24[idx]};
            mag = sum[23] ? 23'h7FFFFF : sum[22:0];
        end
`else
        if (sh >= 9'd24) begin
            mag = 23'd0;
        end else begin
            mag = 23'(m24 >> sh);
        end
`endif
        return {w[31], mag};
    endfunction

    assign e_in_s      = in_data[30:23];
    assign count_inc_s = count_r + {{(CW-1){1'b0}}, 1'b1};

    // Handshake decode and next-state selection.
    always_comb begin
        accept_s     = in_valid && in_ready;
        emit_hs_s    = out_valid && out_ready;
        max_next_s   = (e_in_s > max_e_r) ? e_in_s : max_e_r;
        next_state_s = state_r;
        case (state_r)
            COLLECT: begin
                if (accept_s && (count_r == LAST)) begin
                    next_state_s = EMIT;
                end else begin
                    next_state_s = COLLECT;
                end
            end
            EMIT: begin
                if (emit_hs_s && (count_r == LAST)) begin
                    next_state_s = COLLECT;
                end else begin
                    next_state_s = EMIT;
                end
            end
            default: next_state_s = COLLECT;
        endcase
    end

    // Element storage; contents are don't-care until written in COLLECT.
    always_ff @(posedge clk) begin
        if ((state_r == COLLECT) && accept_s) begin
            buffer_r[count_r] <= in_data;
        end
    end

    // Control state, running max exponent and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= COLLECT;
            count_r       <= '0;
            max_e_r       <= 8'd0;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            out_sign_frac <= '0;
            out_exp       <= '0;
            out_last      <= 1'b0;
            exp_overflow  <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            in_ready  <= (next_state_s == COLLECT);
            out_valid <= (next_state_s == EMIT);
            case (state_r)
                COLLECT: begin
                    if (accept_s) begin
                        max_e_r <= max_next_s;
                        if (count_r == LAST) begin
                            count_r       <= '0;
                            exp_overflow  <= ({1'b0, max_next_s} > EXP_MAX);
                            out_exp       <= ({1'b0, max_next_s} > EXP_MAX) ? '1
                                             : max_next_s[output_exponent_size-1:0];
                            // buffer[0] was written on an earlier accept since block_size >= 2.
                            out_sign_frac <= align(buffer_r[0], max_next_s);
                            out_last      <= 1'b0;
                        end else begin
                            count_r <= count_inc_s;
                        end
                    end
                end
                EMIT: begin
                    if (emit_hs_s) begin
                        if (count_r == LAST) begin
                            count_r       <= '0;
                            max_e_r       <= 8'd0;
                            exp_overflow  <= 1'b0;
                            out_exp       <= '0;
                            out_sign_frac <= '0;
                            out_last      <= 1'b0;
                        end else begin
                            count_r       <= count_inc_s;
                            out_sign_frac <= align(buffer_r[count_inc_s], max_e_r);
                            out_last      <= (count_inc_s == LAST);
                        end
                    end
                end
                default: begin
                    count_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bfp_normalization.sv
// Directed self-checking bench for bfp_normalization; a second instance with a 6-bit exponent shares the stimulus.
module tb_bfp_normalization;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        in_ready, out_valid, out_last, exp_overflow;
    logic [23:0] out_sign_frac;
    logic [7:0]  out_exp;
    logic        in_ready6, out_valid6, out_last6, exp_overflow6;
    logic [23:0] out_sign_frac6;
    logic [5:0]  out_exp6;

    int errors = 0;
    int checks = 0;

    logic [31:0] blk_in  [8];
    logic [23:0] blk_exp [8];

    bfp_normalization #(.output_sign_fraction_size(24), .output_exponent_size(8), .block_size(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sign_frac(out_sign_frac),
        .out_exp(out_exp), .out_last(out_last), .exp_overflow(exp_overflow)
    );

    bfp_normalization #(.output_sign_fraction_size(24), .output_exponent_size(6), .block_size(8)) dut6 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready6), .in_data(in_data),
        .out_valid(out_valid6), .out_ready(out_ready), .out_sign_frac(out_sign_frac6),
        .out_exp(out_exp6), .out_last(out_last6), .exp_overflow(exp_overflow6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_block();
        for (int i = 0; i < 8; i++) begin
            int budget = 0;
            in_valid = 1'b1;
            in_data  = blk_in[i];
            while (!in_ready && budget < 20) begin
                step();
                budget++;
            end
            check_val("in_ready_wait", {31'd0, in_ready}, 32'd1);
            step();
        end
        in_valid = 1'b0;
        check_val("latency_out_valid", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic drain_block(input logic [7:0] e_exp, input logic ovf_exp,
                               input logic [5:0] e6_exp, input bit stall);
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'b1;
            if (stall && i == 4) begin
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    step();
                    check_val("stall_word", {8'd0, out_sign_frac}, {8'd0, blk_exp[i]});
                    check_val("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    check_val("stall_valid", {31'd0, out_valid}, 32'd1);
                end
                out_ready = 1'b1;
            end
            check_val("out_valid", {31'd0, out_valid}, 32'd1);
            check_val("word", {8'd0, out_sign_frac}, {8'd0, blk_exp[i]});
            check_val("out_exp", {24'd0, out_exp}, {24'd0, e_exp});
            check_val("ovf", {31'd0, exp_overflow}, {31'd0, ovf_exp});
            check_val("out_last", {31'd0, out_last}, (i == 7) ? 32'd1 : 32'd0);
            check_val("in_ready_emit", {31'd0, in_ready}, 32'd0);
            check_val("out_exp6", {26'd0, out_exp6}, {26'd0, e6_exp});
            check_val("ovf6", {31'd0, exp_overflow6}, 32'd1);
            check_val("word6", {8'd0, out_sign_frac6}, {8'd0, blk_exp[i]});
            step();
        end
        out_ready = 1'b0;
        check_val("post_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("post_valid", {31'd0, out_valid}, 32'd0);
        check_val("post_ovf", {31'd0, exp_overflow}, 32'd0);
        check_val("post_ovf6", {31'd0, exp_overflow6}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        repeat (3) step();
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_word", {8'd0, out_sign_frac}, 32'd0);
        check_val("rst_out_exp", {24'd0, out_exp}, 32'd0);
        check_val("rst_out_last", {31'd0, out_last}, 32'd0);
        check_val("rst_ovf", {31'd0, exp_overflow}, 32'd0);
        rst = 1'b0;
        step();
        check_val("rst_release_in_ready", {31'd0, in_ready}, 32'd1);

        // Eight 1.0 values
        for (int i = 0; i < 8; i++) begin
            blk_in[i]  = 32'h3F800000;
            blk_exp[i] = 24'h400000;
        end
        send_block();
        drain_block(8'd127, 1'b0, 6'd63, 1'b0);

        // Mixed block with shared exponent 128, stalled at element 4
        blk_in[0] = 32'h40000000; blk_exp[0] = 24'h400000;
        blk_in[1] = 32'h3F800000; blk_exp[1] = 24'h200000;
        blk_in[2] = 32'hBF000000; blk_exp[2] = 24'h900000;
        blk_in[3] = 32'h00000000; blk_exp[3] = 24'h000000;
        blk_in[4] = 32'h80000000; blk_exp[4] = 24'h800000;
        blk_in[5] = 32'h31000000; blk_exp[5] = 24'h000000;
        blk_in[6] = 32'h3F800000; blk_exp[6] = 24'h200000;
        blk_in[7] = 32'h3F800000; blk_exp[7] = 24'h200000;
        send_block();
        drain_block(8'd128, 1'b0, 6'd63, 1'b1);

        // Reset after three accepts of a larger-exponent block
        in_valid = 1'b1;
        in_data  = 32'h40800000;
        repeat (3) step();
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        check_val("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            blk_in[i]  = 32'h3F800000;
            blk_exp[i] = 24'h400000;
        end
        send_block();
        drain_block(8'd127, 1'b0, 6'd63, 1'b0);

        // Rounding behaviour on discarded low bits
        for (int i = 0; i < 8; i++) begin
            blk_in[i]  = 32'h3F800000;
            blk_exp[i] = 24'h400000;
        end
        blk_in[1] = 32'h3F800001;
`ifdef BFP_ROUND_EN
        blk_exp[1] = 24'h400001;
`else
        blk_exp[1] = 24'h400000;
`endif
        blk_in[2]  = 32'h3FFFFFFF;
        blk_exp[2] = 24'h7FFFFF;
        send_block();
        drain_block(8'd127, 1'b0, 6'd63, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
